// File: rtl/tile_row_sequencer.sv
// Streams command rows into a systolic tile and tracks outstanding tile completions.
// Optional completion-order checking is enabled with the TILE_SEQ_ID_CHECK_EN macro.
module tile_row_sequencer #(
    parameter int ROWS_W  = 5,
    parameter int ID_W    = 3,
    parameter int MAX_OUT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROWS_W-1:0] cmd_rows,
    input  logic              cmd_dataflow,
    input  logic [4:0]        cmd_shift,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [7:0]        row_a,
    input  logic [19:0]       row_b,
    input  logic [19:0]       row_d,
    output logic              tile_in_valid,
    output logic [7:0]        tile_in_a,
    output logic [19:0]       tile_in_b,
    output logic [19:0]       tile_in_d,
    output logic              tile_in_dataflow,
    output logic              tile_in_propagate,
    output logic [4:0]        tile_in_shift,
    output logic [ID_W-1:0]   tile_in_id,
    output logic              tile_in_last,
    input  logic              tile_out_valid,
    input  logic              tile_out_last,
    input  logic [ID_W-1:0]   tile_out_id,
    output logic              busy,
    output logic              done,
    output logic [ID_W-1:0]   done_id,
    output logic              err,
    output logic              fsm_state
);

    // Handshakes: a transfer happens on a rising clock edge where valid && ready;
    // valid may be held without ready, ready never depends on valid.
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    localparam logic [ID_W-1:0]   MAX_OUT_C = ID_W'(MAX_OUT);
    localparam logic [ROWS_W-1:0] ONE_ROW   = ROWS_W'(1);

    state_t            state;
    state_t            next_state;
    logic              cmd_take;
    logic              row_fire;
    logic              row_last;
    logic              comp_take;
    logic [ROWS_W-1:0] rows_left;
    logic              cur_dataflow;
    logic [4:0]        cur_shift;
    logic [ID_W-1:0]   cur_id;
    logic              propagate;
    logic [ID_W-1:0]   id_ctr;
    logic [ID_W-1:0]   outstanding;

    assign fsm_state = (state == STREAM);
    assign busy      = (state != IDLE) || (outstanding != '0);
    assign comp_take = tile_out_valid && tile_out_last && (outstanding != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        row_ready  = 1'b0;
        cmd_take   = 1'b0;
        row_fire   = 1'b0;
        row_last   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = (outstanding < MAX_OUT_C);
                // A zero-row command is consumed by the handshake but starts nothing.
                if (cmd_valid && (outstanding < MAX_OUT_C) && (cmd_rows != '0)) begin
                    cmd_take   = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    row_fire = 1'b1;
                    row_last = (rows_left == ONE_ROW);
                    if (row_last) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rows_left         <= '0;
            cur_dataflow      <= 1'b0;
            cur_shift         <= '0;
            cur_id            <= '0;
            propagate         <= 1'b0;
            id_ctr            <= '0;
            outstanding       <= '0;
            tile_in_valid     <= 1'b0;
            tile_in_a         <= '0;
            tile_in_b         <= '0;
            tile_in_d         <= '0;
            tile_in_dataflow  <= 1'b0;
            tile_in_propagate <= 1'b0;
            tile_in_shift     <= '0;
            tile_in_id        <= '0;
            tile_in_last      <= 1'b0;
            done              <= 1'b0;
            done_id           <= '0;
        end else begin
            done          <= comp_take;
            tile_in_valid <= row_fire;
            if (comp_take) begin
                done_id <= tile_out_id;
            end
            if (cmd_take) begin
                rows_left    <= cmd_rows;
                cur_dataflow <= cmd_dataflow;
                cur_shift    <= cmd_shift;
                cur_id       <= id_ctr;
                propagate    <= ~propagate;
                id_ctr       <= id_ctr + 1'b1;
            end
            // Operands only move on a row transfer, so they hold while idle or stalled.
            if (row_fire) begin
                rows_left         <= rows_left - 1'b1;
                tile_in_a         <= row_a;
                tile_in_b         <= row_b;
                tile_in_d         <= row_d;
                tile_in_dataflow  <= cur_dataflow;
                tile_in_propagate <= propagate;
                tile_in_shift     <= cur_shift;
                tile_in_id        <= cur_id;
                tile_in_last      <= row_last;
            end
            case ({cmd_take, comp_take})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef TILE_SEQ_ID_CHECK_EN
    // Completions must return oldest-first: the oldest live id is id_ctr - outstanding.
    logic [ID_W-1:0] exp_id;
    assign exp_id = id_ctr - outstanding;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (tile_out_valid && tile_out_last &&
                     ((outstanding == '0) || (tile_out_id != exp_id))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tile_row_sequencer.sv
// Self-checking bench for tile_row_sequencer: reference model plus scoreboard queues
// for tile input beats and completion pulses.
module tb_tile_row_sequencer;

    localparam int ROWS_W  = 5;
    localparam int ID_W    = 3;
    localparam int MAX_OUT = 4;
    localparam int BW      = 59;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ROWS_W-1:0] cmd_rows = '0;
    logic              cmd_dataflow = 1'b0;
    logic [4:0]        cmd_shift = '0;
    logic              row_valid = 1'b0;
    logic              row_ready;
    logic [7:0]        row_a = '0;
    logic [19:0]       row_b = '0;
    logic [19:0]       row_d = '0;
    logic              tile_in_valid;
    logic [7:0]        tile_in_a;
    logic [19:0]       tile_in_b;
    logic [19:0]       tile_in_d;
    logic              tile_in_dataflow;
    logic              tile_in_propagate;
    logic [4:0]        tile_in_shift;
    logic [ID_W-1:0]   tile_in_id;
    logic              tile_in_last;
    logic              tile_out_valid = 1'b0;
    logic              tile_out_last = 1'b0;
    logic [ID_W-1:0]   tile_out_id = '0;
    logic              busy;
    logic              done;
    logic [ID_W-1:0]   done_id;
    logic              err;
    logic              fsm_state;

    tile_row_sequencer #(.ROWS_W(ROWS_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
        .cmd_dataflow(cmd_dataflow), .cmd_shift(cmd_shift),
        .row_valid(row_valid), .row_ready(row_ready),
        .row_a(row_a), .row_b(row_b), .row_d(row_d),
        .tile_in_valid(tile_in_valid), .tile_in_a(tile_in_a), .tile_in_b(tile_in_b),
        .tile_in_d(tile_in_d), .tile_in_dataflow(tile_in_dataflow),
        .tile_in_propagate(tile_in_propagate), .tile_in_shift(tile_in_shift),
        .tile_in_id(tile_in_id), .tile_in_last(tile_in_last),
        .tile_out_valid(tile_out_valid), .tile_out_last(tile_out_last),
        .tile_out_id(tile_out_id),
        .busy(busy), .done(done), .done_id(done_id), .err(err), .fsm_state(fsm_state)
    );

    // Clock / reset: posedge at 5, 15, ...; inputs change on negedges.
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    int              m_left;
    int              m_out;
    logic [ID_W-1:0] m_id_ctr;
    logic [ID_W-1:0] m_cur_id;
    logic            m_prop;
    logic            m_df;
    logic [4:0]      m_shift;
    logic            m_err;
    logic [BW-1:0]   last_beat;
    logic [BW-1:0]   exp_q[$];
    logic [ID_W-1:0] done_q[$];
    logic [BW-1:0]   beat;

    assign beat = {tile_in_a, tile_in_b, tile_in_d, tile_in_dataflow, tile_in_propagate,
                   tile_in_shift, tile_in_id, tile_in_last};

    function automatic void reset_model();
        m_left    = 0;
        m_out     = 0;
        m_id_ctr  = '0;
        m_cur_id  = '0;
        m_prop    = 1'b0;
        m_df      = 1'b0;
        m_shift   = '0;
        m_err     = 1'b0;
        last_beat = '0;
        exp_q.delete();
        done_q.delete();
    endfunction

    // Scoreboard: sample handshakes just before each posedge, compare just after it.
    initial begin
        logic cmd_acc;
        reset_model();
        forever begin
            @(negedge clock);
            #2;
            if (!reset_n) begin
                reset_model();
            end else begin
                check_eq("cmd_ready", cmd_ready, (m_left == 0) && (m_out < MAX_OUT));
                check_eq("row_ready", row_ready, m_left != 0);
                check_eq("busy", busy, (m_left != 0) || (m_out != 0));
                cmd_acc = cmd_valid && (m_left == 0) && (m_out < MAX_OUT) && (cmd_rows != '0);
                if (row_valid && m_left != 0) begin
                    exp_q.push_back({row_a, row_b, row_d, m_df, m_prop, m_shift, m_cur_id,
                                     (m_left == 1)});
                    m_left--;
                end
                if (tile_out_valid && tile_out_last) begin
`ifdef TILE_SEQ_ID_CHECK_EN
                    if (m_out == 0 || tile_out_id != ID_W'(int'(m_id_ctr) - m_out)) m_err = 1'b1;
`endif
                    if (m_out != 0) begin
                        done_q.push_back(tile_out_id);
                        m_out--;
                    end
                end
                if (cmd_acc) begin
                    m_left   = int'(cmd_rows);
                    m_df     = cmd_dataflow;
                    m_shift  = cmd_shift;
                    m_cur_id = m_id_ctr;
                    m_id_ctr = m_id_ctr + 1'b1;
                    m_prop   = ~m_prop;
                    m_out++;
                end
            end
            @(posedge clock);
            #1;
            if (!reset_n) begin
                reset_model();
            end else begin
                if (exp_q.size() != 0) begin
                    last_beat = exp_q.pop_front();
                    check_eq("tile_in_valid", tile_in_valid, 1'b1);
                    check_eq("tile_in_beat", beat, last_beat);
                end else begin
                    check_eq("tile_in_valid", tile_in_valid, 1'b0);
                    check_eq("tile_in_hold", beat, last_beat);
                end
                if (done_q.size() != 0) begin
                    check_eq("done", done, 1'b1);
                    check_eq("done_id", done_id, done_q.pop_front());
                end else begin
                    check_eq("done", done, 1'b0);
                end
                check_eq("err", err, m_err);
            end
        end
    end

    // Driver tasks: each starts and ends on a negedge.
    task automatic send_cmd(input int rows, input logic df, input logic [4:0] sh);
        logic got;
        int   n;
        cmd_valid    = 1'b1;
        cmd_rows     = ROWS_W'(rows);
        cmd_dataflow = df;
        cmd_shift    = sh;
        n = 0;
        forever begin
            #1;
            got = cmd_ready;
            @(negedge clock);
            if (got) break;
            n++;
            if (n > 200) begin
                check_eq("cmd_timeout", 1'b1, 1'b0);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_row(input int stall);
        logic got;
        int   n;
        row_valid = 1'b0;
        repeat (stall) @(negedge clock);
        row_valid = 1'b1;
        row_a = 8'($urandom);
        row_b = 20'($urandom);
        row_d = 20'($urandom);
        n = 0;
        forever begin
            #1;
            got = row_ready;
            @(negedge clock);
            if (got) break;
            n++;
            if (n > 200) begin
                check_eq("row_timeout", 1'b1, 1'b0);
                break;
            end
        end
        row_valid = 1'b0;
    endtask

    task automatic complete(input logic [ID_W-1:0] id);
        tile_out_valid = 1'b1;
        tile_out_last  = 1'b1;
        tile_out_id    = id;
        @(negedge clock);
        tile_out_valid = 1'b0;
        tile_out_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_tile_in_valid", tile_in_valid, 1'b0);
        check_eq("rst_tile_in_beat", beat, '0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_done_id", done_id, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_fsm_state", fsm_state, 1'b0);
        check_eq("rst_err", err, 1'b0);
    endtask

    logic [ID_W-1:0] nid;
    logic            exp_err_final;

    initial begin
        @(negedge clock);
        check_reset_outputs();
        reset_n = 1'b1;
        idle(1);

        // Three-row command, rows every cycle: id 0, propagate 1, last on beat 3.
        send_cmd(3, 1'b1, 5'd4);
        repeat (3) send_row(0);
        complete(3'd0);
        idle(2);

        // Back-to-back two-row commands.
        send_cmd(2, 1'b0, 5'd7);
        repeat (2) send_row(0);
        send_cmd(2, 1'b1, 5'd1);
        repeat (2) send_row(0);
        complete(3'd1);
        complete(3'd2);
        idle(1);

        // Fill to MAX_OUT, then one completion reopens cmd_ready.
        for (int i = 0; i < MAX_OUT; i++) begin
            send_cmd(1, i[0], 5'(i));
            send_row(0);
        end
        #1;
        check_eq("full_cmd_ready", cmd_ready, 1'b0);
        @(negedge clock);
        complete(3'd3);
        #1;
        check_eq("reopen_done", done, 1'b1);
        check_eq("reopen_done_id", done_id, 3'd3);
        check_eq("reopen_cmd_ready", cmd_ready, 1'b1);
        @(negedge clock);
        complete(3'd4);
        complete(3'd5);
        complete(3'd6);

        // Zero-row command is dropped; the next command still gets id 7.
        send_cmd(0, 1'b1, 5'd9);
        idle(2);
        nid = 3'd7;

        // Random commands with stalls, completed in order.
        for (int i = 0; i < 8; i++) begin
            int rows;
            rows = $urandom_range(1, 6);
            send_cmd(rows, 1'($urandom), 5'($urandom));
            for (int r = 0; r < rows; r++) send_row($urandom_range(0, 2));
            complete(nid);
            nid = nid + 1'b1;
        end
        idle(2);

        // Completion with nothing outstanding: no done pulse.
        complete(3'd5);
        idle(2);

        // Reset in the middle of a five-row command.
        send_cmd(5, 1'b1, 5'd3);
        repeat (2) send_row(0);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        idle(2);
        reset_n = 1'b1;
        send_cmd(2, 1'b0, 5'd2);
        send_row(0);
        #2;
        check_eq("post_reset_id", tile_in_id, 3'd0);
        check_eq("post_reset_prop", tile_in_propagate, 1'b1);
        @(negedge clock);
        send_row(1);
        complete(3'd0);
        idle(1);

        // Out-of-order completions after a fresh reset.
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        send_cmd(1, 1'b0, 5'd0);
        send_row(0);
        send_cmd(1, 1'b0, 5'd0);
        send_row(0);
        complete(3'd1);
        complete(3'd0);
        idle(2);
`ifdef TILE_SEQ_ID_CHECK_EN
        exp_err_final = 1'b1;
`else
        exp_err_final = 1'b0;
`endif
        check_eq("ooo_err", err, exp_err_final);
        idle(2);
        check_eq("ooo_err_sticky", err, exp_err_final);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
